// File: rtl/trd_pc_file.sv
// trd_pc_file: per-thread program counter file with miss replay, branch redirect, sequential fetch and optional exception entry/return.
// Optional feature macro: TRD_PC_EXC_EN (per-thread EPC register and RUN/EXC FSM; ports are identical either way).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cur_trd, i_rd                  thread fetching this cycle, fetch accepted (advances its PC)
//   stall                          blocks branch redirect and increment only
//   jmp/jmp_trd/jmp_pc             resolved branch redirect
//   i_miss/i_miss_trd/i_miss_pc    I-cache miss replay
//   d_miss/d_miss_trd/d_miss_pc    D-cache miss replay (highest priority)
//   jmp_exp/exp_trd/exp_pc         exception entry, trapping PC saved to EPC
//   return_op/ret_trd              exception return to EPC
//   fetch_pc                       combinational PC of cur_trd
//   pc_vec                         all PCs, thread t at [t*PC_W +: PC_W]
//   exp_mode                       per-thread exception state (registered)
//   redirect                       one-cycle pulse after a non-increment PC write
module trd_pc_file #(
   parameter int              NUM_TRD  = 8,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] START_PC = 32'h0001_0100,
   parameter logic [PC_W-1:0] HANDLER  = 32'h0001_0000,
   parameter logic [PC_W-1:0] PC_INC   = 1,
   localparam int             TID_W    = $clog2(NUM_TRD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [TID_W-1:0]        cur_trd,
   input  logic                    i_rd,
   input  logic                    stall,
   input  logic                    jmp,
   input  logic [TID_W-1:0]        jmp_trd,
   input  logic [PC_W-1:0]         jmp_pc,
   input  logic                    i_miss,
   input  logic [TID_W-1:0]        i_miss_trd,
   input  logic [PC_W-1:0]         i_miss_pc,
   input  logic                    d_miss,
   input  logic [TID_W-1:0]        d_miss_trd,
   input  logic [PC_W-1:0]         d_miss_pc,
   input  logic                    jmp_exp,
   input  logic [TID_W-1:0]        exp_trd,
   input  logic [PC_W-1:0]         exp_pc,
   input  logic                    return_op,
   input  logic [TID_W-1:0]        ret_trd,
   output logic [PC_W-1:0]         fetch_pc,
   output logic [NUM_TRD*PC_W-1:0] pc_vec,
   output logic [NUM_TRD-1:0]      exp_mode,
   output logic [NUM_TRD-1:0]      redirect
);

   logic [PC_W-1:0]    pc_q [NUM_TRD];
   logic [PC_W-1:0]    pc_d [NUM_TRD];
   logic [PC_W-1:0]    ret_pc [NUM_TRD];
   logic [NUM_TRD-1:0] redirect_q, redirect_d;
   logic [NUM_TRD-1:0] exc_go, ret_go;

`ifdef TRD_PC_EXC_EN
   typedef enum logic {RUN, EXC} state_e;
   state_e             state_q [NUM_TRD];
   state_e             state_d [NUM_TRD];
   logic [PC_W-1:0]    epc_q [NUM_TRD];
   logic [PC_W-1:0]    epc_d [NUM_TRD];
   logic [NUM_TRD-1:0] miss;

   // A same-thread cache miss drops entry/return entirely, so the FSM and EPC stay put.
   always_comb begin
      for (int t = 0; t < NUM_TRD; t++) begin
         miss[t]   = (d_miss && d_miss_trd == TID_W'(t)) || (i_miss && i_miss_trd == TID_W'(t));
         exc_go[t] = jmp_exp && exp_trd == TID_W'(t) && state_q[t] == RUN && !miss[t];
         ret_go[t] = return_op && ret_trd == TID_W'(t) && state_q[t] == EXC && !miss[t];
      end
   end

   always_comb begin
      for (int t = 0; t < NUM_TRD; t++) begin
         state_d[t] = exc_go[t] ? EXC : ret_go[t] ? RUN : state_q[t];
         epc_d[t]   = exc_go[t] ? exp_pc : epc_q[t];
         ret_pc[t]  = epc_q[t];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < NUM_TRD; t++) begin
            state_q[t] <= RUN;
            epc_q[t]   <= START_PC;
         end
      end else begin
         for (int t = 0; t < NUM_TRD; t++) begin
            state_q[t] <= state_d[t];
            epc_q[t]   <= epc_d[t];
         end
      end
   end

   always_comb begin
      for (int t = 0; t < NUM_TRD; t++) exp_mode[t] = state_q[t] == EXC;
   end
`else
   logic unused_exc;
   assign unused_exc = ^{jmp_exp, exp_trd, exp_pc, return_op, ret_trd};
   assign exc_go     = '0;
   assign ret_go     = '0;
   assign exp_mode   = '0;
   always_comb begin
      for (int t = 0; t < NUM_TRD; t++) ret_pc[t] = START_PC;
   end
`endif

   // Per-thread next PC in strict priority order; only the increment path leaves redirect low.
   always_comb begin
      for (int t = 0; t < NUM_TRD; t++) begin
         pc_d[t] = (d_miss && d_miss_trd == TID_W'(t)) ? d_miss_pc :
                   (i_miss && i_miss_trd == TID_W'(t)) ? i_miss_pc :
                   exc_go[t]                           ? HANDLER   :
                   ret_go[t]                           ? ret_pc[t] :
                   (jmp && !stall && jmp_trd == TID_W'(t)) ? jmp_pc :
                   (i_rd && !stall && cur_trd == TID_W'(t)) ? pc_q[t] + PC_INC : pc_q[t];
         redirect_d[t] = (d_miss && d_miss_trd == TID_W'(t)) || (i_miss && i_miss_trd == TID_W'(t)) ||
                         exc_go[t] || ret_go[t] || (jmp && !stall && jmp_trd == TID_W'(t));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < NUM_TRD; t++) pc_q[t] <= START_PC;
         redirect_q <= '0;
      end else begin
         for (int t = 0; t < NUM_TRD; t++) pc_q[t] <= pc_d[t];
         redirect_q <= redirect_d;
      end
   end

   always_comb begin
      for (int t = 0; t < NUM_TRD; t++) pc_vec[t*PC_W +: PC_W] = pc_q[t];
   end

   assign fetch_pc = pc_q[cur_trd];
   assign redirect = redirect_q;

endmodule

// File: doc/trd_pc_file.md
TRD_PC_FILE -- requirements
Module: trd_pc_file

Interface
REQ-001 Parameter NUM_TRD, 8, number of hardware threads (power of two, 2..16); TID_W = log2(NUM_TRD).
REQ-002 Parameter PC_W, 32, PC width in bits.
REQ-003 Parameter START_PC, 32'h0001_0100, reset PC of every thread and reset EPC value.
REQ-004 Parameter HANDLER, 32'h0001_0000, exception handler entry PC.
REQ-005 Parameter PC_INC, 1, sequential increment added on fetch.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-007 clk  in  1  clock, all state updates on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 cur_trd  in  TID_W  thread currently fetching.
REQ-010 i_rd  in  1  fetch accepted for cur_trd this cycle.
REQ-011 stall  in  1  pipeline stall; blocks jmp and increment only.
REQ-012 jmp, jmp_trd, jmp_pc  in  1/TID_W/PC_W  resolved branch redirect.
REQ-013 i_miss, i_miss_trd, i_miss_pc  in  1/TID_W/PC_W  I-cache miss replay.
REQ-014 d_miss, d_miss_trd, d_miss_pc  in  1/TID_W/PC_W  D-cache miss replay.
REQ-015 jmp_exp, exp_trd, exp_pc  in  1/TID_W/PC_W  exception entry request, trapping PC.
REQ-016 return_op, ret_trd  in  1/TID_W  exception return request.
REQ-017 fetch_pc  out  PC_W  combinational read of PC register of cur_trd.
REQ-018 pc_vec  out  NUM_TRD*PC_W  all thread PCs, thread t at bits [t*PC_W +: PC_W].
REQ-019 exp_mode  out  NUM_TRD  per-thread exception state, registered.
REQ-020 redirect  out  NUM_TRD  registered one-cycle pulse when a thread PC was written by anything other than increment.

Function
REQ-021 Each thread t SHALL hold registers pc[t], epc[t] and a two-state FSM {RUN, EXC}; exp_mode[t]=1 iff EXC.
REQ-022 Per thread, next-PC priority SHALL be: d_miss > i_miss > exception entry > return > jmp(!stall) > increment(cur_trd==t & !stall & i_rd) > hold.
REQ-023 Exception entry for t (jmp_exp & exp_trd==t & state RUN, not overridden): pc<=HANDLER, epc<=exp_pc, state<=EXC.
REQ-024 jmp_exp to a thread already in EXC SHALL be ignored (no nesting); epc and pc unchanged unless a lower-priority event applies.
REQ-025 Return for t (return_op & ret_trd==t & state EXC, not overridden): pc<=epc[t], state<=RUN; return_op in RUN SHALL be ignored.
REQ-026 An exception entry or return overridden by d_miss/i_miss on the same thread SHALL be dropped entirely: FSM and epc unchanged.
REQ-027 Increment SHALL be pc+PC_INC modulo 2^PC_W (all-ones wraps to PC_INC-1).
REQ-028 Events targeting different threads in one cycle SHALL all take effect independently.
REQ-029 All updates SHALL be visible on pc_vec/fetch_pc/exp_mode the cycle after the triggering edge; redirect[t] asserts that same cycle for exactly one cycle per write.
REQ-030 Exception entry and return SHALL not be gated by stall.

Reset
REQ-031 While rst_n=0: every pc[t]=START_PC, epc[t]=START_PC, state RUN, exp_mode=0, redirect=0; fetch_pc=START_PC.
REQ-032 Reset asserted mid-operation SHALL abort any pending update immediately; first post-reset edge behaves as from clean state.

Configuration
REQ-033 Macro TRD_PC_EXC_EN defined: exception FSM and epc registers present per REQ-021..026.
REQ-034 Macro TRD_PC_EXC_EN undefined: no epc/FSM registers; jmp_exp, exp_trd, exp_pc, return_op, ret_trd ignored; exp_mode tied 0; ports unchanged.

Verification
REQ-035 Reset then cur_trd=3, i_rd=1, stall=0 for 3 cycles -> pc_vec thread3 = 0x0001_0103, others 0x0001_0100, redirect=0.
REQ-036 Same cycle: d_miss thread2 pc 0x200, jmp thread2 pc 0x300, jmp_exp thread2 -> pc[2]=0x200, exp_mode[2]=0, redirect[2] pulses once.
REQ-037 jmp_exp thread5 exp_pc 0x0001_0140 -> pc[5]=0x0001_0000, exp_mode[5]=1; second jmp_exp exp_pc 0x999 ignored; return_op thread5 -> pc[5]=0x0001_0140, exp_mode[5]=0.
REQ-038 stall=1 with jmp thread1 and increment thread1 -> pc[1] unchanged; i_miss thread1 pc 0x44 with stall=1 -> pc[1]=0x44.
REQ-039 pc[0] preset to 0xFFFF_FFFF via jmp, then increment -> pc[0]=0x0000_0000.
REQ-040 Without TRD_PC_EXC_EN: jmp_exp thread0 -> pc[0] and exp_mode unchanged, redirect=0.
